// File: rtl/mem_lsu_pkg.sv
// Shared constants, state encoding and op record for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic        ENABLE          = 1'b1;
  localparam logic        DISABLE         = 1'b0;
  localparam logic [31:0] DEFAULT_32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Attributes of the access in flight, latched at acceptance.
  typedef struct packed {
    logic       is_store;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
    logic [4:0] rd;
    logic       wb_en;
  } lsu_op_t;

  // True when funct3 is a defined access size and the address is naturally aligned for it.
  function automatic logic access_ok(input logic is_store, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~addr_lo[0];
        F3_SW:   ok = (addr_lo == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~addr_lo[0];
        F3_LW:         ok = (addr_lo == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store replication/byte enables and load extraction/extension.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] load_data_c
);

  logic [DATA_W-1:0] shifted;

  // Lane selection for both directions of the access.
  always_comb begin
    shifted     = rdata >> {addr_lo, 3'b000};
    be_c        = 4'b1111;
    wdata_c     = store_data;
    load_data_c = shifted;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          be_c    = 4'(4'b0001 << addr_lo);
          wdata_c = {(DATA_W/8){store_data[7:0]}};
        end
        F3_SH: begin
          be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_c = {(DATA_W/16){store_data[15:0]}};
        end
        default: ;
      endcase
    end
    case (funct3)
      F3_LB:   load_data_c = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data_c = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_LH:   load_data_c = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data_c = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: load_data_c = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs req/ack data-bus accesses and feeds MEM/WB.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              exmem_valid_i,
  input  logic              exmem_wb_en_i,
  input  logic [6:0]        exmem_opcode_i,
  input  logic [2:0]        exmem_funct3_i,
  input  logic [ADDR_W-1:0] exmem_addr_i,
  input  logic [DATA_W-1:0] exmem_wdata_i,
  input  logic [4:0]        exmem_rd_i,
  output logic              lsu_stall_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  output logic [3:0]        dbus_be_o,
  input  logic              dbus_ack_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  output logic              memwb_valid_o,
  output logic              memwb_wb_en_o,
  output logic [4:0]        memwb_rd_o,
  output logic [DATA_W-1:0] memwb_data_o,
  output logic              lsu_misalign_o,
  output logic              lsu_timeout_o
);

  localparam int unsigned       CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(DEFAULT_32_ZERO);

  lsu_state_e        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  lsu_op_t           op_q, op_nx;

  logic              req_nx, we_nx, mv_nx, mwb_nx, mis_nx, to_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx, data_nx;
  logic [3:0]        be_nx;
  logic [4:0]        rd_nx;

  logic              is_store, is_mem, legal;
  logic              al_is_store;
  logic [2:0]        al_funct3;
  logic [1:0]        al_addr_lo;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata, al_load;

  // Decode of the instruction currently offered by EX/MEM.
  always_comb begin
    is_store = (exmem_opcode_i == OPCODE_STORE);
    is_mem   = (exmem_opcode_i == OPCODE_LOAD) || is_store;
    legal    = access_ok(is_store, exmem_funct3_i, exmem_addr_i[1:0]);
  end

  // Lane logic sees the incoming op while idle and the latched op afterwards.
  always_comb begin
    if (state == ST_IDLE) begin
      al_is_store = is_store;
      al_funct3   = exmem_funct3_i;
      al_addr_lo  = exmem_addr_i[1:0];
    end else begin
      al_is_store = op_q.is_store;
      al_funct3   = op_q.funct3;
      al_addr_lo  = op_q.addr_lo;
    end
  end

  mem_lsu_align #(.DATA_W(DATA_W)) u_align (
    .is_store    (al_is_store),
    .funct3      (al_funct3),
    .addr_lo     (al_addr_lo),
    .store_data  (exmem_wdata_i),
    .rdata       (dbus_rdata_i),
    .be_c        (al_be),
    .wdata_c     (al_wdata),
    .load_data_c (al_load)
  );

  // Next-state, stall and next values of the registered outputs.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    op_nx       = op_q;
    req_nx      = dbus_req_o;
    we_nx       = dbus_we_o;
    addr_nx     = dbus_addr_o;
    wdata_nx    = dbus_wdata_o;
    be_nx       = dbus_be_o;
    mv_nx       = DISABLE;
    mwb_nx      = DISABLE;
    rd_nx       = memwb_rd_o;
    data_nx     = memwb_data_o;
    mis_nx      = DISABLE;
    to_nx       = DISABLE;
    lsu_stall_o = DISABLE;
    case (state)
      ST_IDLE: begin
        if (exmem_valid_i) begin
          if (!is_mem) begin
            mv_nx   = ENABLE;
            mwb_nx  = exmem_wb_en_i;
            rd_nx   = exmem_rd_i;
            data_nx = DATA_W'(exmem_addr_i);
          end else if (!legal) begin
            mv_nx   = ENABLE;
            rd_nx   = exmem_rd_i;
            data_nx = ZERO_DATA;
            mis_nx  = ENABLE;
          end else begin
            lsu_stall_o    = ENABLE;
            op_nx.is_store = is_store;
            op_nx.funct3   = exmem_funct3_i;
            op_nx.addr_lo  = exmem_addr_i[1:0];
            op_nx.rd       = exmem_rd_i;
            op_nx.wb_en    = exmem_wb_en_i;
            req_nx         = ENABLE;
            we_nx          = is_store;
            addr_nx        = {exmem_addr_i[ADDR_W-1:2], 2'b00};
            wdata_nx       = al_wdata;
            be_nx          = al_be;
            cnt_nx         = '0;
            state_nx       = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        lsu_stall_o = ENABLE;
        if (dbus_ack_i) begin
          req_nx   = DISABLE;
          mv_nx    = ENABLE;
          mwb_nx   = op_q.wb_en & ~op_q.is_store;
          rd_nx    = op_q.rd;
          data_nx  = op_q.is_store ? ZERO_DATA : al_load;
          state_nx = ST_RESP;
        end else if (cnt == CNT_LAST) begin
          req_nx   = DISABLE;
          mv_nx    = ENABLE;
          rd_nx    = op_q.rd;
          data_nx  = ZERO_DATA;
          to_nx    = ENABLE;
          state_nx = ST_RESP;
        end else begin
          cnt_nx = CNT_W'(cnt + 1'b1);
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      op_q           <= '0;
      dbus_req_o     <= DISABLE;
      dbus_we_o      <= DISABLE;
      dbus_addr_o    <= '0;
      dbus_wdata_o   <= '0;
      dbus_be_o      <= '0;
      memwb_valid_o  <= DISABLE;
      memwb_wb_en_o  <= DISABLE;
      memwb_rd_o     <= '0;
      memwb_data_o   <= '0;
      lsu_misalign_o <= DISABLE;
      lsu_timeout_o  <= DISABLE;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      op_q           <= op_nx;
      dbus_req_o     <= req_nx;
      dbus_we_o      <= we_nx;
      dbus_addr_o    <= addr_nx;
      dbus_wdata_o   <= wdata_nx;
      dbus_be_o      <= be_nx;
      memwb_valid_o  <= mv_nx;
      memwb_wb_en_o  <= mwb_nx;
      memwb_rd_o     <= rd_nx;
      memwb_data_o   <= data_nx;
      lsu_misalign_o <= mis_nx;
      lsu_timeout_o  <= to_nx;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases plus random ops against an arithmetic reference model.
module tb_mem_lsu;

  localparam int unsigned TO = 255;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rest;
  logic        exmem_valid, exmem_wb_en;
  logic [6:0]  exmem_opcode;
  logic [2:0]  exmem_funct3;
  logic [31:0] exmem_addr, exmem_wdata;
  logic [4:0]  exmem_rd;
  logic        lsu_stall, dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, memwb_data;
  logic [3:0]  dbus_be;
  logic        memwb_valid, memwb_wb_en, lsu_misalign, lsu_timeout;
  logic [4:0]  memwb_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rest           (rest),
    .exmem_valid_i  (exmem_valid),
    .exmem_wb_en_i  (exmem_wb_en),
    .exmem_opcode_i (exmem_opcode),
    .exmem_funct3_i (exmem_funct3),
    .exmem_addr_i   (exmem_addr),
    .exmem_wdata_i  (exmem_wdata),
    .exmem_rd_i     (exmem_rd),
    .lsu_stall_o    (lsu_stall),
    .dbus_req_o     (dbus_req),
    .dbus_we_o      (dbus_we),
    .dbus_addr_o    (dbus_addr),
    .dbus_wdata_o   (dbus_wdata),
    .dbus_be_o      (dbus_be),
    .dbus_ack_i     (dbus_ack),
    .dbus_rdata_i   (dbus_rdata),
    .memwb_valid_o  (memwb_valid),
    .memwb_wb_en_o  (memwb_wb_en),
    .memwb_rd_o     (memwb_rd),
    .memwb_data_o   (memwb_data),
    .lsu_misalign_o (lsu_misalign),
    .lsu_timeout_o  (lsu_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Access size in bytes encoded by funct3.
  function automatic int unsigned size_of(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz;
    sz = size_of(f3);
    if (st) return (f3 < 3) && ((addr % sz) == 0);
    return (f3 != 3) && (f3 < 6) && ((addr % sz) == 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned m;
    m = ((32'd1 << size_of(f3)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    if (f3 == 3'd0) return {24'd0, rs2[7:0]} * 32'h0101_0101;
    if (f3 == 3'd1) return {16'd0, rs2[15:0]} * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned nb;
    logic [31:0] v, mask;
    nb = size_of(f3);
    v  = word >> (8 * (addr % 4));
    if (nb == 4) return v;
    mask = (32'd1 << (8 * nb)) - 1;
    v    = v & mask;
    if (f3[2] == 1'b0 && ((v >> (8 * nb - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    return v;
  endfunction

  // Offer one instruction at EX/MEM (called just after a rising edge, unit idle) and
  // act as the bus slave; ack_delay >= TO means the ack is never given.
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic wb,
                        input int ack_delay, input logic [31:0] word);
    bit is_ld, is_st, ok, acked;
    int reqs, guard;
    is_ld = (opc == OP_LOAD);
    is_st = (opc == OP_STORE);
    ok    = model_legal(is_st, f3, addr);
    exmem_valid  = 1'b1;
    exmem_opcode = opc;
    exmem_funct3 = f3;
    exmem_addr   = addr;
    exmem_wdata  = rs2;
    exmem_rd     = rd;
    exmem_wb_en  = wb;
    dbus_ack     = (is_ld || is_st) ? 1'b0 : 1'($urandom);
    @(negedge clk);
    check("stall_accept", {31'd0, lsu_stall}, {31'd0, (is_ld || is_st) && ok});
    check("req_idle", {31'd0, dbus_req}, 32'd0);
    if (!(is_ld || is_st) || !ok) begin
      @(posedge clk); #1;
      exmem_valid = 1'b0;
      dbus_ack    = 1'b0;
      @(negedge clk);
      check("nomem_valid", {31'd0, memwb_valid}, 32'd1);
      check("nomem_wb_en", {31'd0, memwb_wb_en}, {31'd0, !(is_ld || is_st) && wb});
      check("nomem_misalign", {31'd0, lsu_misalign}, {31'd0, is_ld || is_st});
      check("nomem_req", {31'd0, dbus_req}, 32'd0);
      check("nomem_stall", {31'd0, lsu_stall}, 32'd0);
      if (!(is_ld || is_st)) begin
        check("pass_rd", {27'd0, memwb_rd}, {27'd0, rd});
        check("pass_data", memwb_data, addr);
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("nomem_valid_drop", {31'd0, memwb_valid}, 32'd0);
      check("misalign_drop", {31'd0, lsu_misalign}, 32'd0);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      @(negedge clk);
      reqs  = 0;
      guard = 0;
      acked = 0;
      while (dbus_req === 1'b1 && guard < int'(TO) + 4) begin
        check("bus_addr", dbus_addr, {addr[31:2], 2'b00});
        if (reqs == 0) begin
          check("bus_we", {31'd0, dbus_we}, {31'd0, is_st});
          check("bus_be", {28'd0, dbus_be}, is_st ? {28'd0, model_be(f3, addr)} : 32'hF);
          if (is_st) check("bus_wdata", dbus_wdata, model_wdata(f3, rs2));
        end
        check("stall_req", {31'd0, lsu_stall}, 32'd1);
        reqs++;
        if (ack_delay == reqs - 1) begin
          dbus_ack   = 1'b1;
          dbus_rdata = word;
          acked      = 1;
        end
        @(posedge clk); #1;
        dbus_ack   = 1'b0;
        dbus_rdata = $urandom;
        @(negedge clk);
        guard++;
      end
      check("req_cycles", reqs, acked ? ack_delay + 1 : int'(TO));
      check("resp_valid", {31'd0, memwb_valid}, 32'd1);
      check("resp_rd", {27'd0, memwb_rd}, {27'd0, rd});
      check("resp_wb_en", {31'd0, memwb_wb_en}, {31'd0, acked && is_ld && wb});
      check("resp_timeout", {31'd0, lsu_timeout}, {31'd0, !acked});
      check("resp_stall", {31'd0, lsu_stall}, 32'd0);
      if (acked && is_ld) check("load_data", memwb_data, model_load(f3, addr, word));
      @(posedge clk); #1;
      exmem_valid = 1'b0;
      @(negedge clk);
      check("post_valid", {31'd0, memwb_valid}, 32'd0);
      check("post_timeout", {31'd0, lsu_timeout}, 32'd0);
      check("post_req", {31'd0, dbus_req}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rest = 1'b1;
    exmem_valid = 1'b0; exmem_wb_en = 1'b0; exmem_opcode = '0; exmem_funct3 = '0;
    exmem_addr = '0; exmem_wdata = '0; exmem_rd = '0; dbus_ack = 1'b0; dbus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, dbus_req}, 32'd0);
    check("rst_stall", {31'd0, lsu_stall}, 32'd0);
    check("rst_valid", {31'd0, memwb_valid}, 32'd0);
    check("rst_data", memwb_data, 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_pulses", {30'd0, lsu_misalign, lsu_timeout}, 32'd0);
    rest = 1'b0;
    @(posedge clk); #1;

    run_op(OP_ADD,   3'd0, 32'h0000_1234, 32'h0,         5'd5,  1'b1, 0,  32'h0);
    run_op(OP_LOAD,  3'd0, 32'h0000_1003, 32'h0,         5'd7,  1'b1, 0,  32'h80FF_0011);
    run_op(OP_STORE, 3'd1, 32'h0000_2002, 32'hAAAA_BEEF, 5'd3,  1'b1, 0,  32'h0);
    run_op(OP_LOAD,  3'd2, 32'h0000_3001, 32'h0,         5'd9,  1'b1, 0,  32'h0);
    run_op(OP_LOAD,  3'd2, 32'h0000_4000, 32'h0,         5'd10, 1'b1, TO, 32'h0);
    run_op(OP_LOAD,  3'd2, 32'h0000_4004, 32'h0,         5'd11, 1'b1, TO - 1, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a bus request.
    exmem_valid = 1'b1; exmem_opcode = OP_LOAD; exmem_funct3 = 3'd2;
    exmem_addr = 32'h40; exmem_rd = 5'd12; exmem_wb_en = 1'b1; dbus_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", {31'd0, dbus_req}, 32'd1);
    @(posedge clk); #3;
    rest = 1'b1;
    exmem_valid = 1'b0;
    #1;
    check("async_rst_req", {31'd0, dbus_req}, 32'd0);
    check("async_rst_stall", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    rest = 1'b0;
    @(negedge clk);
    dbus_ack = 1'b1;
    dbus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_valid", {31'd0, memwb_valid}, 32'd0);
    check("stray_ack_req", {31'd0, dbus_req}, 32'd0);
    @(posedge clk); #1;
    run_op(OP_LOAD, 3'd5, 32'h0000_0052, 32'h0, 5'd13, 1'b1, 1, 32'h9ABC_8001);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 3) begin
        exmem_valid = 1'b0;
        dbus_ack    = 1'($urandom);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        check("idle_valid", {31'd0, memwb_valid}, 32'd0);
        check("idle_req", {31'd0, dbus_req}, 32'd0);
        @(posedge clk); #1;
      end else begin
        logic [6:0] opc;
        opc = (kind == 0) ? (($urandom_range(0, 1) == 0) ? OP_ADD : OP_ADDI)
                          : ((kind == 1) ? OP_LOAD : OP_STORE);
        run_op(opc, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
               1'($urandom), $urandom_range(0, 3), $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
